pwm_cfg_loader: RTL and testbench

PWM_CFG_LOADER -- requirements
Module: pwm_cfg_loader

---
 rtl/pwm_cfg_loader.sv | 147 ++++++++++++++
 tb/tb_pwm_cfg_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_cfg_loader.sv
// Byte-serial configuration loader for a PWM generator: assembles period/duty
// frames from a host byte stream and commits them as two back-to-back writes.
module pwm_cfg_loader #(
  parameter int TIMEOUT  = 255,
  parameter int DUTY_MAX = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  byte_in,
  input  logic        byte_stb,
  output logic [11:0] cfg_in,
  output logic        cfg_sel,
  output logic        cfg_wr_en,
  output logic        busy,
  output logic [2:0]  err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIM   = CW'(TIMEOUT);
  localparam logic [11:0]   DUTY_LIM = 12'(DUTY_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_LO = 2'd1,
    WR_PER  = 2'd2,
    WR_DUTY = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic          isDuty_q, isDuty_d;
  logic [3:0]    hi_q, hi_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [11:0]   per_q, per_d;
  logic [11:0]   duty_q, duty_d;
  logic [11:0]   cfgIn_q, cfgIn_d;
  logic          cfgSel_q, cfgSel_d;
  logic          wrEn_q, wrEn_d;
  logic          busy_q, busy_d;
  logic [2:0]    err_q, err_d;
  logic [11:0]   word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      isDuty_q <= 1'b0;
      hi_q     <= 4'd0;
      cnt_q    <= '0;
      per_q    <= 12'd0;
      duty_q   <= 12'd0;
      cfgIn_q  <= 12'd0;
      cfgSel_q <= 1'b0;
      wrEn_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      isDuty_q <= isDuty_d;
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      cfgIn_q  <= cfgIn_d;
      cfgSel_q <= cfgSel_d;
      wrEn_q   <= wrEn_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    isDuty_d = isDuty_q;
    hi_d     = hi_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    duty_d   = duty_q;
    cfgIn_d  = cfgIn_q;
    cfgSel_d = cfgSel_q;
    wrEn_d   = 1'b0;
    err_d    = err_q;
    word     = {hi_q, byte_in};

    case (state_q)
      IDLE: begin
        if (byte_stb) begin
          case (byte_in[7:6])
            2'b00, 2'b01: begin
              isDuty_d = byte_in[6];
              hi_d     = byte_in[3:0];
              cnt_d    = '0;
              state_d  = WAIT_LO;
            end
            2'b10: state_d = WR_PER;
            default: begin
              // Clear wins over any flag set; no set source is active in IDLE.
              per_d  = 12'd0;
              duty_d = 12'd0;
              err_d  = 3'd0;
            end
          endcase
        end
      end
      WAIT_LO: begin
        if (byte_stb) begin
          state_d = IDLE;
          if (!isDuty_q) begin
            per_d = word;
          end else if (word > DUTY_LIM) begin
            duty_d   = DUTY_LIM;
            err_d[1] = 1'b1;
          end else begin
            duty_d = word;
          end
        end else if (cnt_q == TO_LIM) begin
          err_d[0] = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR_PER: begin
        wrEn_d   = 1'b1;
        cfgSel_d = 1'b1;
        cfgIn_d  = per_q;
        state_d  = WR_DUTY;
        if (byte_stb) err_d[2] = 1'b1;
      end
      default: begin
        wrEn_d   = 1'b1;
        cfgSel_d = 1'b0;
        cfgIn_d  = duty_q;
        state_d  = IDLE;
        if (byte_stb) err_d[2] = 1'b1;
      end
    endcase

    // Busy also covers the duty pulse cycle, so it drops only after the last write.
    busy_d = (state_d != IDLE) || wrEn_d;
  end

  assign cfg_in    = cfgIn_q;
  assign cfg_sel   = cfgSel_q;
  assign cfg_wr_en = wrEn_q;
  assign busy      = busy_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pwm_cfg_loader.sv
// Directed bench for pwm_cfg_loader; expected downstream writes are queued
// when a commit is issued and checked by a monitor as pulses appear.
module tb_pwm_cfg_loader;

  localparam int TIMEOUT  = 255;
  localparam int DUTY_MAX = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_stb = 1'b0;
  logic [11:0] cfg_in;
  logic        cfg_sel;
  logic        cfg_wr_en;
  logic        busy;
  logic [2:0]  err;

  int total = 0;
  int bad   = 0;
  logic [12:0] expQ[$];

  pwm_cfg_loader #(.TIMEOUT(TIMEOUT), .DUTY_MAX(DUTY_MAX)) dut (
    .clk       (clk),
    .rst       (rst),
    .byte_in   (byte_in),
    .byte_stb  (byte_stb),
    .cfg_in    (cfg_in),
    .cfg_sel   (cfg_sel),
    .cfg_wr_en (cfg_wr_en),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the byte is sampled on the following rising edge.
  task automatic applyStimulus(input logic [7:0] b);
    byte_in  = b;
    byte_stb = 1'b1;
    @(negedge clk);
    byte_stb = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic expectCommit(input logic [11:0] per, input logic [11:0] duty);
    expQ.push_back({1'b1, per});
    expQ.push_back({1'b0, duty});
  endtask

  // Monitor: every write pulse must match the head of the scoreboard.
  initial begin
    logic [12:0] e;
    forever begin
      @(negedge clk);
      if (cfg_wr_en) begin
        total++;
        assert (expQ.size() != 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_write observed=%0h expected=none", {cfg_sel, cfg_in});
        end
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("write_word", {3'd0, cfg_sel, cfg_in}, {3'd0, e});
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    idle(2);
    applyStimulus(8'h80);
    idle(1);
    rst = 1'b0;
    idle(1);
    checkOutput("reset_cfg_in", cfg_in, 0);
    checkOutput("reset_sel", cfg_sel, 0);
    checkOutput("reset_wr_en", cfg_wr_en, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_err", err, 0);

    // Basic frames and commit latency
    applyStimulus(8'h03);
    checkOutput("busy_mid_frame", busy, 1);
    applyStimulus(8'hE8);
    applyStimulus(8'h40);
    applyStimulus(8'h32);
    expectCommit(12'h3E8, 12'h032);
    applyStimulus(8'h80);
    checkOutput("commit_n0_busy", busy, 1);
    checkOutput("commit_n0_wr", cfg_wr_en, 0);
    @(negedge clk);
    checkOutput("commit_n1_wr", cfg_wr_en, 1);
    checkOutput("commit_n1_sel", cfg_sel, 1);
    @(negedge clk);
    checkOutput("commit_n2_wr", cfg_wr_en, 1);
    checkOutput("commit_n2_sel", cfg_sel, 0);
    @(negedge clk);
    checkOutput("commit_n3_wr", cfg_wr_en, 0);
    checkOutput("commit_n3_busy", busy, 0);
    idle(2);
    checkOutput("hold_cfg_in", cfg_in, 12'h032);
    checkOutput("hold_sel", cfg_sel, 0);
    checkOutput("basic_err", err, 0);

    // Repeated commit rewrites the same staged values
    expectCommit(12'h3E8, 12'h032);
    applyStimulus(8'h80);
    idle(4);

    // Duty boundary: exactly DUTY_MAX passes, above it is clamped
    applyStimulus(8'h40);
    applyStimulus(8'h64);
    idle(1);
    checkOutput("duty_at_max_err", err, 0);
    applyStimulus(8'h40);
    applyStimulus(8'h65);
    idle(1);
    checkOutput("duty_101_err", err, 3'b010);
    applyStimulus(8'h40);
    applyStimulus(8'hC8);
    expectCommit(12'h3E8, 12'h064);
    applyStimulus(8'h80);
    idle(4);
    checkOutput("clamp_err", err, 3'b010);

    // Clear command
    applyStimulus(8'hC0);
    idle(2);
    checkOutput("clear_err", err, 0);
    checkOutput("clear_busy", busy, 0);
    expectCommit(12'h000, 12'h000);
    applyStimulus(8'h80);
    idle(4);

    // Timeout: partial frame discarded, staged period kept
    applyStimulus(8'h01);
    applyStimulus(8'h23);
    applyStimulus(8'h05);
    idle(TIMEOUT - 1);
    checkOutput("timeout_pending_busy", busy, 1);
    checkOutput("timeout_pending_err", err, 0);
    idle(2);
    checkOutput("timeout_err", err, 3'b001);
    checkOutput("timeout_busy", busy, 0);
    expectCommit(12'h123, 12'h000);
    applyStimulus(8'h80);
    idle(4);

    // A slow but in-time data byte is still accepted
    applyStimulus(8'h04);
    idle(100);
    applyStimulus(8'h56);
    expectCommit(12'h456, 12'h000);
    applyStimulus(8'h80);
    idle(4);

    // Strobe during commit is dropped and flagged
    applyStimulus(8'hC0);
    applyStimulus(8'h02);
    applyStimulus(8'hBC);
    expectCommit(12'h2BC, 12'h000);
    applyStimulus(8'h80);
    applyStimulus(8'h12);
    idle(4);
    checkOutput("drop_err", err, 3'b100);
    checkOutput("drop_busy", busy, 0);

    // Reset during the period pulse suppresses the duty pulse
    expQ.push_back({1'b1, 12'h2BC});
    applyStimulus(8'h80);
    @(negedge clk);
    checkOutput("rst_commit_wr", cfg_wr_en, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_commit_in", cfg_in, 0);
    checkOutput("rst_commit_sel", cfg_sel, 0);
    checkOutput("rst_commit_wr0", cfg_wr_en, 0);
    checkOutput("rst_commit_busy", busy, 0);
    checkOutput("rst_commit_err", err, 0);
    idle(4);

    // Reset mid-frame, then clear after a fresh error
    applyStimulus(8'h0A);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8'h40);
    applyStimulus(8'hFF);
    idle(1);
    checkOutput("post_rst_clamp_err", err, 3'b010);
    applyStimulus(8'hC0);
    idle(2);
    checkOutput("post_rst_clear_err", err, 0);
    expectCommit(12'h000, 12'h000);
    applyStimulus(8'h80);
    idle(5);

    checkOutput("queue_drained", 16'(expQ.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
